c2h_stream_sink: RTL and testbench

C2H_STREAM_SINK -- requirements
Module: c2h_stream_sink

---
 rtl/c2h_pkg.sv | 25 ++
 rtl/c2h_stream_sink_if.sv | 29 ++
 rtl/c2h_credit_table.sv | 80 ++++++++
 rtl/c2h_stream_sink.sv | 162 ++++++++++++++++
 tb/tb_c2h_stream_sink.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/c2h_pkg.sv
// C2H stream sink: shared FSM encoding, default widths and beat sizing.
// Imported by the interface, the credit table and the top level.
package c2h_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SCAN,
        RET
    } c2h_state_e;

    localparam int C2H_DATA_W = 512;
    localparam int C2H_CRDT_W = 16;
    localparam int C2H_BPB    = C2H_DATA_W / 8;
    localparam int C2H_QID_W  = 11;

    // Beats needed to carry sz bytes; an empty transfer still takes one beat.
    function automatic logic [16:0] exp_beats(input logic [15:0] sz,
                                              input int bpb);
        logic [31:0] n;
        n = (32'(sz) + 32'(bpb) - 32'd1) / 32'(bpb);
        return (n == 32'd0) ? 17'd1 : n[16:0];
    endfunction

endpackage

// File: rtl/c2h_stream_sink_if.sv
// Stream-in and descriptor-credit-return handshake bundle.
// The sink uses the slave view; the traffic source uses the master view.
interface c2h_stream_sink_if #(
    parameter int DATA_W = c2h_pkg::C2H_DATA_W
);
    import c2h_pkg::*;

    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_W-1:0]    s_data;
    logic                 s_last;
    logic [C2H_QID_W-1:0] s_qid;

    logic                 tm_dsc_sts_vld;
    logic                 tm_dsc_sts_rdy;
    logic [C2H_QID_W-1:0] tm_dsc_sts_qid;
    logic [15:0]          tm_dsc_sts_avl;

    modport master (
        output s_valid, s_data, s_last, s_qid, tm_dsc_sts_rdy,
        input  s_ready, tm_dsc_sts_vld, tm_dsc_sts_qid, tm_dsc_sts_avl
    );

    modport slave (
        input  s_valid, s_data, s_last, s_qid, tm_dsc_sts_rdy,
        output s_ready, tm_dsc_sts_vld, tm_dsc_sts_qid, tm_dsc_sts_avl
    );

endinterface

// File: rtl/c2h_credit_table.sv
// Per-queue outstanding/consumed credit counters, saturating.
// One consume port, one return port; both may hit the same entry in a cycle.
module c2h_credit_table
    import c2h_pkg::*;
#(
    parameter int NQ     = 16,
    parameter int CRDT_W = C2H_CRDT_W,
    parameter int IW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              cons_vld_i,
    input  logic [IW-1:0]     cons_idx_i,
    output logic              cons_zero_o,
    input  logic              ret_vld_i,
    input  logic [IW-1:0]     ret_idx_i,
    input  logic [CRDT_W-1:0] ret_avl_i,
    input  logic [IW-1:0]     rd_idx_i,
    output logic [CRDT_W-1:0] rd_cons_o
);

    localparam logic [CRDT_W-1:0] ONE = CRDT_W'(1);

    logic [CRDT_W-1:0] out_q  [NQ];
    logic [CRDT_W-1:0] out_d  [NQ];
    logic [CRDT_W-1:0] cons_q [NQ];
    logic [CRDT_W-1:0] cons_d [NQ];
    logic [CRDT_W-1:0] o, c;

    function automatic logic [CRDT_W-1:0] sat_add(input logic [CRDT_W-1:0] a,
                                                  input logic [CRDT_W-1:0] b);
        logic [CRDT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CRDT_W] ? '1 : s[CRDT_W-1:0];
    endfunction

    function automatic logic [CRDT_W-1:0] sat_sub(input logic [CRDT_W-1:0] a,
                                                  input logic [CRDT_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    assign cons_zero_o = (out_q[cons_idx_i] == '0);
    assign rd_cons_o   = cons_q[rd_idx_i];

    // Return is applied before the consume so a same-entry collision nets both.
    always_comb begin
        o = '0;
        c = '0;
        for (int i = 0; i < NQ; i++) begin
            o = out_q[i];
            c = cons_q[i];
            if (ret_vld_i && ret_idx_i == IW'(i)) begin
                o = sat_add(o, ret_avl_i);
                c = sat_sub(c, ret_avl_i);
            end
            if (cons_vld_i && cons_idx_i == IW'(i)) begin
                o = sat_sub(o, ONE);
                c = sat_add(c, ONE);
            end
            out_d[i]  = o;
            cons_d[i] = c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NQ; i++) begin
                out_q[i]  <= '0;
                cons_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NQ; i++) begin
                out_q[i]  <= clr_i ? '0 : out_d[i];
                cons_q[i] <= clr_i ? '0 : cons_d[i];
            end
        end
    end

endmodule

// File: rtl/c2h_stream_sink.sv
// C2H stream sink: accepts packets per queue, checks length/qid/credit,
// and hands consumed descriptors back as credit returns.
module c2h_stream_sink
    import c2h_pkg::*;
#(
    parameter int DATA_W  = C2H_DATA_W,
    parameter int NQ      = 16,
    parameter int CRDT_W  = C2H_CRDT_W,
    parameter int RET_THR = 32
) (
    input  logic                axi_aclk,
    input  logic                axi_aresetn,
    input  logic                enable,
    input  logic                pause,
    input  logic [15:0]         txr_size,
    input  logic [10:0]         num_queue,
    input  logic [CRDT_W-1:0]   init_credit,
    c2h_stream_sink_if.slave    bus,
    output logic [31:0]         pkt_count,
    output logic                err_len,
    output logic                err_qid,
    output logic                err_crdt
);

    localparam int IW  = (NQ > 1) ? $clog2(NQ) : 1;
    localparam int BPB = DATA_W / 8;
    localparam logic [CRDT_W-1:0] THR = CRDT_W'(RET_THR);

    c2h_state_e        state_q, state_d;
    logic [10:0]       q_q, q_d;
    logic [CRDT_W-1:0] avl_q, avl_d;
    logic              en_q, in_pkt_q;
    logic [16:0]       beat_q;
    logic [31:0]       pkt_q;
    logic              err_len_q, err_qid_q, err_crdt_q;

    logic              rise, start, fire, sop, qid_ok, cons_vld, cons_zero;
    logic              ret_fire, q_last;
    logic [10:0]       q_nxt;
    logic [16:0]       exp_n;
    logic [CRDT_W-1:0] ret_avl, rd_cons;

    assign rise     = enable && !en_q;
    assign start    = rise && (state_q == IDLE);
    assign fire     = bus.s_valid && bus.s_ready;
    assign sop      = fire && !in_pkt_q;
    assign qid_ok   = (bus.s_qid < num_queue) && (bus.s_qid < 11'(NQ));
    assign cons_vld = sop && qid_ok;
    assign exp_n    = exp_beats(txr_size, BPB);
    assign ret_fire = bus.tm_dsc_sts_vld && bus.tm_dsc_sts_rdy;
    assign ret_avl  = (state_q == INIT) ? init_credit : avl_q;
    assign q_last   = (q_q + 11'd1) >= num_queue;
    assign q_nxt    = q_last ? 11'd0 : q_q + 11'd1;

    assign bus.s_ready = enable && !pause &&
                         (state_q == SCAN || state_q == RET);
    assign bus.tm_dsc_sts_vld = (state_q == INIT) || (state_q == RET);
    assign bus.tm_dsc_sts_qid = q_q;
    assign bus.tm_dsc_sts_avl = 16'(ret_avl);

    assign pkt_count = pkt_q;
    assign err_len   = err_len_q;
    assign err_qid   = err_qid_q;
    assign err_crdt  = err_crdt_q;

    c2h_credit_table #(
        .NQ     (NQ),
        .CRDT_W (CRDT_W),
        .IW     (IW)
    ) u_tbl (
        .clk         (axi_aclk),
        .rst_n       (axi_aresetn),
        .clr_i       (start),
        .cons_vld_i  (cons_vld),
        .cons_idx_i  (bus.s_qid[IW-1:0]),
        .cons_zero_o (cons_zero),
        .ret_vld_i   (ret_fire),
        .ret_idx_i   (q_q[IW-1:0]),
        .ret_avl_i   (ret_avl),
        .rd_idx_i    (q_q[IW-1:0]),
        .rd_cons_o   (rd_cons)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        avl_d   = avl_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = INIT;
                    q_d     = '0;
                end
            end
            INIT: begin
                if (ret_fire) begin
                    q_d = q_nxt;
                    if (!enable)     state_d = IDLE;
                    else if (q_last) state_d = SCAN;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (rd_cons >= THR) begin
                    state_d = RET;
                    avl_d   = rd_cons;
                end else begin
                    q_d = q_nxt;
                end
            end
            RET: begin
                if (ret_fire) begin
                    q_d     = q_nxt;
                    state_d = enable ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q    <= IDLE;
            q_q        <= '0;
            avl_q      <= '0;
            en_q       <= 1'b0;
            in_pkt_q   <= 1'b0;
            beat_q     <= '0;
            pkt_q      <= '0;
            err_len_q  <= 1'b0;
            err_qid_q  <= 1'b0;
            err_crdt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            avl_q   <= avl_d;
            en_q    <= enable;
            if (start) begin
                in_pkt_q   <= 1'b0;
                beat_q     <= '0;
                pkt_q      <= '0;
                err_len_q  <= 1'b0;
                err_qid_q  <= 1'b0;
                err_crdt_q <= 1'b0;
            end else if (fire) begin
                if (sop && !qid_ok)        err_qid_q  <= 1'b1;
                if (cons_vld && cons_zero) err_crdt_q <= 1'b1;
                if (bus.s_last) begin
                    in_pkt_q <= 1'b0;
                    beat_q   <= '0;
                    pkt_q    <= pkt_q + 32'd1;
                    if (beat_q + 17'd1 != exp_n) err_len_q <= 1'b1;
                end else begin
                    in_pkt_q <= 1'b1;
                    beat_q   <= beat_q + 17'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_c2h_stream_sink.sv
// Directed + randomized bench for c2h_stream_sink against a credit model.
`timescale 1ns/1ps
module tb_c2h_stream_sink;
    import c2h_pkg::*;

    localparam int DW = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] txr_size = 16'd256;
    logic [10:0] num_queue = 11'd4;
    logic [15:0] init_credit = 16'd1024;
    logic [31:0] pkt_count;
    logic        err_len, err_qid, err_crdt;

    int nvec = 0;
    int nerr = 0;

    c2h_stream_sink_if #(.DATA_W(DW)) bus();

    c2h_stream_sink #(
        .DATA_W(DW), .NQ(16), .CRDT_W(16), .RET_THR(32)
    ) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .enable      (enable),
        .pause       (pause),
        .txr_size    (txr_size),
        .num_queue   (num_queue),
        .init_credit (init_credit),
        .bus         (bus.slave),
        .pkt_count   (pkt_count),
        .err_len     (err_len),
        .err_qid     (err_qid),
        .err_crdt    (err_crdt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] qid;
        logic [15:0] avl;
    } ret_t;

    ret_t retq[$];
    ret_t mon_r;

    // Inputs only change just after posedge, so a negedge sample predicts the handshake.
    always @(negedge clk) begin
        if (rst_n && bus.tm_dsc_sts_vld && bus.tm_dsc_sts_rdy) begin
            mon_r.qid = bus.tm_dsc_sts_qid;
            mon_r.avl = bus.tm_dsc_sts_avl;
            retq.push_back(mon_r);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [10:0] q, input logic last);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_qid   = q;
        bus.s_last  = last;
        bus.s_data  = {16{$urandom()}};
        @(negedge clk);
        while (!bus.s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("ready_timeout", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [10:0] q, input int nb);
        for (int i = 0; i < nb; i++) beat(q, i == nb - 1);
    endtask

    // Restart the run and expect one init return per queue before s_ready rises.
    task automatic start_run(input logic [15:0] ic, input string tag);
        int n = 0;
        enable = 1'b0;
        cycles(4);
        chk($sformatf("%s_rdy_low", tag), 64'(bus.s_ready), 64'd0);
        retq.delete();
        init_credit = ic;
        enable = 1'b1;
        @(negedge clk);
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_init_cnt", tag), 64'(retq.size()), 64'd4);
        for (int i = 0; i < 4 && i < retq.size(); i++) begin
            chk($sformatf("%s_init_qid%0d", tag, i), 64'(retq[i].qid), 64'(i));
            chk($sformatf("%s_init_avl%0d", tag, i), 64'(retq[i].avl), 64'(ic));
        end
        chk($sformatf("%s_pkt_clr", tag), 64'(pkt_count), 64'd0);
        chk($sformatf("%s_err_clr", tag),
            64'({err_len, err_qid, err_crdt}), 64'd0);
        retq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sops[4];
        int rsum[4];
        bit m_len, m_qid;
        int q, nb;

        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        bus.s_qid = '0;
        bus.s_data = '0;
        bus.tm_dsc_sts_rdy = 1'b1;

        enable = 1'b1;
        cycles(3);
        chk("rst_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_vld", 64'(bus.tm_dsc_sts_vld), 64'd0);
        chk("rst_qid_avl", 64'({bus.tm_dsc_sts_qid, bus.tm_dsc_sts_avl}), 64'd0);
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        chk("rst_err", 64'({err_len, err_qid, err_crdt}), 64'd0);
        rst_n = 1'b1;

        start_run(16'd1024, "init");

        pause = 1'b1;
        @(negedge clk);
        chk("pause_ready", 64'(bus.s_ready), 64'd0);
        @(posedge clk);
        #1;
        pause = 1'b0;

        for (int i = 0; i < 32; i++) send_pkt(11'd2, 4);
        cycles(20);
        chk("q2_ret_cnt", 64'(retq.size()), 64'd1);
        if (retq.size() > 0) begin
            chk("q2_ret_qid", 64'(retq[0].qid), 64'd2);
            chk("q2_ret_avl", 64'(retq[0].avl), 64'd32);
        end
        chk("q2_pkt", 64'(pkt_count), 64'd32);
        chk("q2_err", 64'({err_len, err_qid, err_crdt}), 64'd0);
        retq.delete();

        send_pkt(11'd0, 3);
        chk("len_err", 64'(err_len), 64'd1);
        chk("len_pkt", 64'(pkt_count), 64'd33);

        send_pkt(11'd5, 4);
        chk("qid_err", 64'(err_qid), 64'd1);
        chk("qid_pkt", 64'(pkt_count), 64'd34);
        cycles(20);
        chk("qid_noret", 64'(retq.size()), 64'd0);

        start_run(16'd1024, "rand");
        m_len = 1'b0;
        m_qid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sops[i] = 0;
            rsum[i] = 0;
        end
        for (int k = 0; k < 200; k++) begin
            q  = $urandom_range(0, 4);
            if (q == 4) q = $urandom_range(4, 20);
            nb = $urandom_range(1, 6);
            if (q < 4) sops[q]++;
            else m_qid = 1'b1;
            if (nb != 4) m_len = 1'b1;
            send_pkt(11'(q), nb);
            if ($urandom_range(0, 3) == 0) cycles(1);
        end
        cycles(60);
        chk("rand_pkt", 64'(pkt_count), 64'd200);
        chk("rand_len", 64'(err_len), 64'(m_len));
        chk("rand_qid", 64'(err_qid), 64'(m_qid));
        chk("rand_crdt", 64'(err_crdt), 64'd0);
        foreach (retq[i]) begin
            chk("rand_ret_qid_ok", 64'(retq[i].qid < 11'd4), 64'd1);
            chk("rand_ret_avl_ok", 64'(retq[i].avl >= 16'd32), 64'd1);
            if (retq[i].qid < 11'd4) rsum[retq[i].qid] += int'(retq[i].avl);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rand_q%0d_ret_le_sop", i),
                64'(rsum[i] <= sops[i]), 64'd1);
            chk($sformatf("rand_q%0d_residue", i),
                64'((sops[i] - rsum[i]) < 32), 64'd1);
        end

        start_run(16'd2, "crdt");
        bus.tm_dsc_sts_rdy = 1'b0;
        send_pkt(11'd0, 4);
        send_pkt(11'd0, 4);
        chk("crdt_ok2", 64'(err_crdt), 64'd0);
        beat(11'd0, 1'b0);
        chk("crdt_err3", 64'(err_crdt), 64'd1);
        beat(11'd0, 1'b0);
        beat(11'd0, 1'b0);
        beat(11'd0, 1'b1);
        chk("crdt_pkt", 64'(pkt_count), 64'd3);

        for (int i = 0; i < 32; i++) send_pkt(11'd1, 4);
        cycles(10);
        chk("ret_vld", 64'(bus.tm_dsc_sts_vld), 64'd1);
        chk("ret_qid", 64'(bus.tm_dsc_sts_qid), 64'd1);
        chk("ret_avl", 64'(bus.tm_dsc_sts_avl), 64'd32);
        send_pkt(11'd1, 4);
        chk("ret_avl_hold", 64'(bus.tm_dsc_sts_avl), 64'd32);
        beat(11'd3, 1'b0);

        rst_n = 1'b0;
        enable = 1'b0;
        bus.tm_dsc_sts_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 64'(bus.s_ready), 64'd0);
        chk("mid_rst_vld", 64'(bus.tm_dsc_sts_vld), 64'd0);
        chk("mid_rst_qid_avl",
            64'({bus.tm_dsc_sts_qid, bus.tm_dsc_sts_avl}), 64'd0);
        chk("mid_rst_pkt", 64'(pkt_count), 64'd0);
        chk("mid_rst_err", 64'({err_len, err_qid, err_crdt}), 64'd0);
        rst_n = 1'b1;
        cycles(2);

        start_run(16'd8, "rst");
        send_pkt(11'd3, 4);
        chk("post_rst_pkt", 64'(pkt_count), 64'd1);
        chk("post_rst_err", 64'({err_len, err_qid, err_crdt}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
